// File: rtl/clk_divider_mc.sv
// clk_divider_mc: multi-channel programmable clock divider.
// Each channel produces a 50% duty square wave with a half-period of n_act+1
// input cycles, a one-cycle strobe on every rising edge, and a RUN indicator.
// A new divisor is loaded only at a period boundary, so no runt pulses occur.
// Optional feature macro: CLKDIV_SYNC_EN adds the I_SYNC phase-align input.
module clk_divider_mc #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic [NCH*WIDTH-1:0] I_N,
    input  logic [NCH-1:0]     I_EN,
`ifdef CLKDIV_SYNC_EN
    input  logic               I_SYNC,
`endif
    output logic [NCH-1:0]     O_CLK,
    output logic [NCH-1:0]     O_TICK,
    output logic [NCH-1:0]     O_RUN
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        state_t             state, state_nxt;
        logic [WIDTH-1:0]   cnt, cnt_nxt;
        logic [WIDTH-1:0]   n_act, n_act_nxt;
        logic               clk_q, clk_nxt;
        logic               tick_q, tick_nxt;
        logic [WIDTH-1:0]   n_in;
        logic               en;

        assign n_in = I_N[i*WIDTH +: WIDTH];
        assign en   = I_EN[i];

        // Next-state logic: counting, edge generation and boundary-only divisor reload
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            n_act_nxt = n_act;
            clk_nxt   = clk_q;
            tick_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    clk_nxt = 1'b0;
                    if (en) begin
                        state_nxt = RUN;
                        n_act_nxt = n_in;
                    end
                end
                RUN: begin
`ifdef CLKDIV_SYNC_EN
                    // Phase alignment restarts the period from the low phase,
                    // deliberately allowed to cut a high phase short.
                    if (I_SYNC) begin
                        cnt_nxt   = '0;
                        clk_nxt   = 1'b0;
                        n_act_nxt = n_in;
                        if (!en) begin
                            state_nxt = IDLE;
                        end
                    end else
`endif
                    if (!clk_q && !en) begin
                        // Stopping in the low phase cannot truncate a pulse.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt != n_act) begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end else if (!clk_q) begin
                        clk_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        // Period end: the only point where the divisor may change
                        // and where a pending disable may take effect.
                        clk_nxt   = 1'b0;
                        cnt_nxt   = '0;
                        n_act_nxt = n_in;
                        if (!en) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end
            endcase
        end

        // Channel state register with synchronous reset
        always_ff @(posedge I_CLK) begin
            if (I_RST) begin
                state  <= IDLE;
                cnt    <= '0;
                n_act  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                n_act  <= n_act_nxt;
                clk_q  <= clk_nxt;
                tick_q <= tick_nxt;
            end
        end

        assign O_CLK[i]  = clk_q;
        assign O_TICK[i] = tick_q;
        assign O_RUN[i]  = (state == RUN);
    end

endmodule

// File: tb/tb_clk_divider_mc.sv
// tb_clk_divider_mc: scoreboard bench for clk_divider_mc.
// The reference model tracks each channel as a position inside its period
// (0 .. 2*half-1) and derives outputs from that position arithmetically.
// Define CLKDIV_SYNC_EN to include the phase-align port and its scenarios.
module tb_clk_divider_mc;

    localparam int NCH   = 4;
    localparam int WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sync;
    logic [NCH*WIDTH-1:0] nv;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       o_clk, o_tick, o_run;

    clk_divider_mc #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .I_CLK  (clk),
        .I_RST  (rst),
        .I_N    (nv),
        .I_EN   (en),
`ifdef CLKDIV_SYNC_EN
        .I_SYNC (sync),
`endif
        .O_CLK  (o_clk),
        .O_TICK (o_tick),
        .O_RUN  (o_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] c;
        logic [NCH-1:0] t;
        logic [NCH-1:0] r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cycle  = 0;

    // Reference model state: active flag, position in period, half-period length
    bit act  [NCH];
    int pos  [NCH];
    int half [NCH];

    task automatic model_edge(input logic r, input logic s);
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            int nin;
            nin = int'(nv[i*WIDTH +: WIDTH]);
            if (r) begin
                act[i] = 0;
                pos[i] = 0;
            end else if (!act[i]) begin
                if (en[i]) begin
                    act[i]  = 1;
                    pos[i]  = 0;
                    half[i] = nin + 1;
                end
            end else if (s) begin
                if (en[i]) begin
                    pos[i]  = 0;
                    half[i] = nin + 1;
                end else begin
                    act[i] = 0;
                end
            end else if (pos[i] < half[i]) begin
                if (!en[i]) act[i] = 0;
                else        pos[i] = pos[i] + 1;
            end else if (pos[i] == 2*half[i] - 1) begin
                if (!en[i]) begin
                    act[i] = 0;
                end else begin
                    pos[i]  = 0;
                    half[i] = nin + 1;
                end
            end else begin
                pos[i] = pos[i] + 1;
            end
            e.c[i] = act[i] && (pos[i] >= half[i]);
            e.t[i] = act[i] && (pos[i] == half[i]);
            e.r[i] = act[i];
        end
        q.push_back(e);
    endtask

    // One clock: inputs already applied, model advances with what the edge samples
    task automatic step(input logic r, input logic s);
        rst  = r;
        sync = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        sync = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic setn(input int ch, input int val);
        nv[ch*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against queued expectation
    always @(negedge clk) begin
        cycle++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({o_clk, o_tick, o_run} !== {e.c, e.t, e.r}) begin
                fails++;
                $display("FAIL outputs cycle %0d: clk/tick/run actual %b/%b/%b required %b/%b/%b",
                         cycle, o_clk, o_tick, o_run, e.c, e.t, e.r);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        sync = 1'b0;
        en   = '0;
        nv   = '0;
        for (int i = 0; i < NCH; i++) begin
            act[i] = 0; pos[i] = 0; half[i] = 1;
        end

        // Reset held two cycles with all enables high, then ch0 N=3 starts
        en = '1;
        setn(0, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        en = 4'b0001;
        steps(14);

        // Periods: ch0 N=0, ch1 N=4, 50 periods of ch1
        en = '0;
        step(1'b1, 1'b0);
        setn(0, 0);
        setn(1, 4);
        en = 4'b0011;
        steps(505);

        // Divisor update mid high phase: ch0 N=2 then 5
        en = '0;
        step(1'b1, 1'b0);
        setn(0, 2);
        en = 4'b0001;
        steps(4);
        setn(0, 5);
        steps(30);

        // Graceful stop in high phase, then stop in low phase
        en = '0;
        step(1'b1, 1'b0);
        setn(0, 5);
        en = 4'b0001;
        steps(8);
        en = 4'b0000;
        steps(14);
        en = 4'b0001;
        steps(3);
        en = 4'b0000;
        steps(3);

        // Boundary: ch1 N=15 (half-period 16), then reset mid high phase
        en = '0;
        step(1'b1, 1'b0);
        setn(1, 15);
        en = 4'b0010;
        steps(75);
        step(1'b1, 1'b0);
        steps(3);

`ifdef CLKDIV_SYNC_EN
        // Phase alignment: ch0 N=1, ch1 N=3 offset by 3 cycles
        en = '0;
        step(1'b1, 1'b0);
        setn(0, 1);
        setn(1, 3);
        en = 4'b0001;
        steps(3);
        en = 4'b0011;
        steps(10);
        step(1'b0, 1'b1);
        steps(40);
`endif

        // Randomized traffic across all channels
        en = '0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            logic s;
            logic r;
            s = 1'b0;
            if ($urandom_range(0, 7) == 0)
                en[$urandom_range(0, NCH-1)] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0)
                setn($urandom_range(0, NCH-1), $urandom_range(0, 15));
            r = ($urandom_range(0, 199) == 0);
`ifdef CLKDIV_SYNC_EN
            s = ($urandom_range(0, 49) == 0);
`endif
            step(r, s);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending expectations actual %0d required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
